// File: rtl/operand_pkg.sv
// Shared types and sizing for the operand collector.
package operand_pkg;

  localparam int NUM_OPS = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } op_state_t;

endpackage

// File: rtl/operand_timeout.sv
// Idle counter that expires after TIMEOUT_CYCLES consecutive running cycles.
// Only instantiated when OPERAND_TIMEOUT_EN is defined.
module operand_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic expire
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // A clear in the expiring cycle wins, so no expiry is reported then.
  assign expire = run && !clr && (r_count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr || expire) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/operand_collector.sv
// Collects four WIDTH-bit operands from a byte stream and presents them in parallel.
// Define OPERAND_TIMEOUT_EN to discard partial sets after TIMEOUT_CYCLES idle cycles.
module operand_collector
  import operand_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       fill,
  output logic             err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("operand_collector: TIMEOUT_CYCLES must be in 1..65535");
  end

  op_state_t        r_state, w_state_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic [WIDTH-1:0] r_ops [NUM_OPS];
  logic             r_in_ready, r_out_valid, r_err;
  logic             w_accept, w_expire;

  // Flush blocks the accept; ready is a registered copy of the state decode.
  assign w_accept  = r_in_ready && in_valid && !flush;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign a         = r_ops[0];
  assign b         = r_ops[1];
  assign c         = r_ops[2];
  assign d         = r_ops[3];
  assign fill      = (r_state == PRESENT) ? 3'(NUM_OPS) : {1'b0, r_idx};
  assign err       = r_err;

`ifdef OPERAND_TIMEOUT_EN
  logic w_run;
  assign w_run = (r_state == COLLECT) && (r_idx != '0);

  operand_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .run   (w_run),
    .clr   (w_accept || flush),
    .expire(w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns the next-state signals and no latch is inferred.
    w_state_next = r_state;
    w_idx_next   = r_idx;
    if (flush) begin
      w_state_next = COLLECT;
      w_idx_next   = '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            if (r_idx == IDX_W'(NUM_OPS - 1)) begin
              w_state_next = PRESENT;
              w_idx_next   = '0;
            end else begin
              w_idx_next = r_idx + IDX_W'(1);
            end
          end else if (w_expire) begin
            w_idx_next = '0;
          end
        end
        PRESENT: begin
          if (out_ready) w_state_next = COLLECT;
        end
      endcase
    end
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= COLLECT;
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_in_ready  <= (w_state_next == COLLECT);
      r_out_valid <= (w_state_next == PRESENT);
      r_err       <= w_expire;
    end
  end

  // NOTE: the operand registers drive outputs directly, so reset clears them too.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OPS; i++) r_ops[i] <= '0;
    end else if (w_accept) begin
      r_ops[r_idx] <= in_data;
    end
  end

endmodule

// File: tb/tb_operand_collector.sv
// Self-checking bench for operand_collector: vector table, random-gap scoreboard, timeout sequences.
module tb_operand_collector;

  localparam int WIDTH = 8;
  localparam int TO    = 4;
`ifdef OPERAND_TIMEOUT_EN
  localparam int MAXG  = 2;
`else
  localparam int MAXG  = 7;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready, out_valid, err;
  logic [WIDTH-1:0] a, b, c, d;
  logic [2:0]       fill;

  operand_collector #(
    .WIDTH(WIDTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid), .out_ready(out_ready), .fill(fill), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic       rst, iv, fl, ordy;
    logic [7:0] din;
    logic       ir, ov;
    logic [2:0] fill;
    logic [7:0] a, b, c, d;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int rst, input int iv, input logic [7:0] din, input int fl,
                     input int ordy, input int ir, input int ov, input int f,
                     input logic [7:0] ea, input logic [7:0] eb,
                     input logic [7:0] ec, input logic [7:0] ed);
    vec_t v;
    v.rst = 1'(rst); v.iv = 1'(iv); v.din = din; v.fl = 1'(fl); v.ordy = 1'(ordy);
    v.ir = 1'(ir); v.ov = 1'(ov); v.fill = 3'(f);
    v.a = ea; v.b = eb; v.c = ec; v.d = ed;
    vecs.push_back(v);
  endtask

  function automatic logic [63:0] observed();
    return {26'b0, in_ready, out_valid, fill, a, b, c, d, err};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q[$];
    logic [31:0] exp_set;
    int sent, sets, gap, cycles;
    logic [7:0] next_byte;

    // rst iv din fl ordy | ir ov fill a b c d
    add(1,0,8'h00,0,0, 0,0,0, 8'h00,8'h00,8'h00,8'h00);  // reset state
    add(0,0,8'h00,0,0, 0,0,0, 8'h00,8'h00,8'h00,8'h00);
    add(0,1,8'h11,0,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00);  // cycle 1
    add(0,1,8'h22,0,1, 1,0,1, 8'h11,8'h00,8'h00,8'h00);
    add(0,1,8'h33,0,1, 1,0,2, 8'h11,8'h22,8'h00,8'h00);
    add(0,1,8'h44,0,1, 1,0,3, 8'h11,8'h22,8'h33,8'h00);
    add(0,0,8'h00,0,1, 0,1,4, 8'h11,8'h22,8'h33,8'h44);  // cycle 5: presented, handshake
    add(0,1,8'h55,0,0, 1,0,0, 8'h11,8'h22,8'h33,8'h44);  // cycle 6: ready again
    add(0,1,8'h66,0,0, 1,0,1, 8'h55,8'h22,8'h33,8'h44);
    add(0,1,8'h77,0,0, 1,0,2, 8'h55,8'h66,8'h33,8'h44);
    add(0,1,8'h88,0,0, 1,0,3, 8'h55,8'h66,8'h77,8'h44);
    for (int i = 0; i < 10; i++)                          // held, 0xFF refused
      add(0,1,8'hFF,0,0, 0,1,4, 8'h55,8'h66,8'h77,8'h88);
    add(0,1,8'hFF,0,1, 0,1,4, 8'h55,8'h66,8'h77,8'h88);  // handshake cycle
    add(0,1,8'h99,0,0, 1,0,0, 8'h55,8'h66,8'h77,8'h88);  // lands in a
    add(0,1,8'hEE,1,0, 1,0,1, 8'h99,8'h66,8'h77,8'h88);  // flush beats in_valid
    add(0,1,8'hAA,0,0, 1,0,0, 8'h99,8'h66,8'h77,8'h88);
    add(0,1,8'hBB,0,0, 1,0,1, 8'hAA,8'h66,8'h77,8'h88);
    add(0,1,8'hCC,1,0, 1,0,2, 8'hAA,8'hBB,8'h77,8'h88);  // 0xCC dropped
    add(0,1,8'h01,0,0, 1,0,0, 8'hAA,8'hBB,8'h77,8'h88);
    add(0,1,8'h02,0,0, 1,0,1, 8'h01,8'hBB,8'h77,8'h88);
    add(0,1,8'h03,0,0, 1,0,2, 8'h01,8'h02,8'h77,8'h88);
    add(0,1,8'h04,0,0, 1,0,3, 8'h01,8'h02,8'h03,8'h88);
    add(0,0,8'h00,1,0, 0,1,4, 8'h01,8'h02,8'h03,8'h04);  // flush a presented set
    add(0,1,8'h10,0,0, 1,0,0, 8'h01,8'h02,8'h03,8'h04);
    add(0,1,8'h20,0,0, 1,0,1, 8'h10,8'h02,8'h03,8'h04);
    add(0,1,8'h30,0,0, 1,0,2, 8'h10,8'h20,8'h03,8'h04);
    add(1,0,8'h00,0,0, 1,0,3, 8'h10,8'h20,8'h30,8'h04);  // reset at fill=3
    add(0,1,8'hEE,0,0, 0,0,0, 8'h00,8'h00,8'h00,8'h00);  // all cleared, not ready
    add(0,1,8'hA1,0,0, 1,0,0, 8'h00,8'h00,8'h00,8'h00);
    add(0,1,8'hA2,0,0, 1,0,1, 8'hA1,8'h00,8'h00,8'h00);
    add(0,1,8'hA3,0,0, 1,0,2, 8'hA1,8'hA2,8'h00,8'h00);
    add(0,1,8'hA4,0,0, 1,0,3, 8'hA1,8'hA2,8'hA3,8'h00);
    add(0,0,8'h00,0,1, 0,1,4, 8'hA1,8'hA2,8'hA3,8'hA4);
    add(0,0,8'h00,0,0, 1,0,0, 8'hA1,8'hA2,8'hA3,8'hA4);

    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset     = vecs[i].rst;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].din;
      flush     = vecs[i].fl;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d", i), observed(),
            {26'b0, vecs[i].ir, vecs[i].ov, vecs[i].fill,
             vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, 1'b0});
    end

    // Random gaps between bytes; scoreboard checks order, loss and duplication.
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sent = 0; sets = 0; cycles = 0; next_byte = 8'h00;
    gap = $urandom_range(0, MAXG);
    while (sets < 100 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 400 && gap == 0) begin
        in_valid = 1'b1;
        in_data  = next_byte;
      end else begin
        in_valid = 1'b0;
        if (gap > 0) gap--;
      end
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        sent++;
        next_byte++;
        gap = $urandom_range(0, MAXG);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() < 4) begin
          check($sformatf("rand_set%0d_avail", sets), 64'(exp_q.size()), 64'd4);
        end else begin
          exp_set = {exp_q[0], exp_q[1], exp_q[2], exp_q[3]};
          repeat (4) void'(exp_q.pop_front());
          check($sformatf("rand_set%0d", sets), {32'b0, a, b, c, d}, {32'b0, exp_set});
        end
        sets++;
      end
    end
    if (sets < 100) check("rand_cycle_budget", 64'(sets), 64'd100);
    check("rand_leftover", 64'(exp_q.size()), 64'd0);

    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b1; in_data = 8'h5A;

`ifdef OPERAND_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check($sformatf("to_idle%0d", k), {60'b0, fill, err}, {60'b0, 3'd1, 1'b0});
    end
    @(negedge clk); #1;
    check("to_expire", {60'b0, fill, err}, {60'b0, 3'd0, 1'b1});
    @(negedge clk); #1;
    check("to_pulse_end", {60'b0, fill, err}, {60'b0, 3'd0, 1'b0});
    in_valid = 1'b1; in_data = 8'h5B;
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h5C;   // accept in the expiring cycle
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("to_accept_wins", {44'b0, fill, err, a, b},
          {44'b0, 3'd2, 1'b0, 8'h5B, 8'h5C});
    @(negedge clk); #1;
    check("to_accept_no_late_err", {60'b0, fill, err}, {60'b0, 3'd2, 1'b0});
`else
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    #1;
    check("no_timeout_partial_kept", {52'b0, fill, err, a}, {52'b0, 3'd1, 1'b0, 8'h5A});
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
